seg_display_mux: RTL

Parametrised multiplexed 7-segment display driver with common-anode digits and active-low segments. It extends the fixed 4-digit hex scanner with:
- configurable digit count
- tear-free double-buffered data load
- leading-zero blanking
- per-digit decimal points and blink
- PWM brightness control
It sits between the status/debug registers of the MIL-STD-1553 core and the board display pins. It also supplies the shared 1 ms clock-enable.

---
 rtl/seg_pkg.sv | 37 +++
 rtl/seg_hex7.sv | 11 +
 rtl/seg_display_mux.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/seg_pkg.sv
// Shared constants and helpers for the 7-segment display blocks: hex glyph
// table (active-low gfedcba), the all-segments-off pattern and a counter-width helper.
package seg_pkg;

   localparam logic [6:0] SEG_OFF = 7'h7F;

   // Index n holds the glyph for hex digit n; bit 6 is segment g, bit 0 is segment a.
   localparam logic [15:0][6:0] HEX7_TABLE = {
      7'b0001110,  // F
      7'b0000110,  // E
      7'b0100001,  // d
      7'b1000110,  // C
      7'b0000011,  // b
      7'b0001000,  // A
      7'b0010000,  // 9
      7'b0000000,  // 8
      7'b1111000,  // 7
      7'b0000010,  // 6
      7'b0010010,  // 5
      7'b0011001,  // 4
      7'b0110000,  // 3
      7'b0100100,  // 2
      7'b1111001,  // 1
      7'b1000000   // 0
   };

   // Bits needed for a counter spanning 0..n-1; never less than one bit.
   function automatic int cnt_width(input int n);
      int w;
      w = 1;
      for (int i = 1; i < 32; i++) begin
         if ((longint'(1) << i) < longint'(n)) w = i + 1;
      end
      return w;
   endfunction

endpackage

// File: rtl/seg_hex7.sv
// Combinational hex nibble to active-low 7-segment glyph, shared by the display blocks.
module seg_hex7
   import seg_pkg::*;
(
   input  logic [3:0] nib,
   output logic [6:0] seg
);

   assign seg = HEX7_TABLE[nib];

endmodule

// File: rtl/seg_display_mux.sv
// Multiplexed common-anode 7-segment driver: double-buffered data, leading-zero
// blanking, per-digit dp and blink, PWM dimming; also sources the shared 1 ms enable.
module seg_display_mux
   import seg_pkg::*;
#(
   parameter int FCLK_KHZ = 50000,
   parameter int NDIG     = 4,
   parameter int BRIGHT_W = 4,
   parameter int BLINK_MS = 250
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [4*NDIG-1:0]   dat,
   input  logic [NDIG-1:0]     dp,
   input  logic                load,
   input  logic                blank_lz,
   input  logic [NDIG-1:0]     blink_mask,
   input  logic [BRIGHT_W-1:0] bright,
   output logic [NDIG-1:0]     AN,
   output logic [6:0]          seg,
   output logic                seg_P,
   output logic                ce1ms
);

   localparam int PRE_W = cnt_width(FCLK_KHZ);
   localparam int IDX_W = cnt_width(NDIG);
   localparam int BLK_W = cnt_width(BLINK_MS);

   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(FCLK_KHZ - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NDIG - 1);
   localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_MS - 1);

   logic [PRE_W-1:0]    pre_cnt;
   logic                tick;
   logic [IDX_W-1:0]    idx;
   logic                frame_end;

   logic [4*NDIG-1:0]   stg_dat;
   logic [NDIG-1:0]     stg_dp;
   logic [4*NDIG-1:0]   shd_dat;
   logic [NDIG-1:0]     shd_dp;
   logic                pending;

   logic [BLK_W-1:0]    ms_cnt;
   logic                blink_phase;
   logic [BRIGHT_W-1:0] pwm_cnt;
   logic                pwm_on;

   logic [NDIG-1:0]     lz_blank;
   logic [3:0]          cur_nib;
   logic                cur_dp;
   logic                cur_blink;
   logic                cur_lz;
   logic [6:0]          hex_seg;

   logic [NDIG-1:0]     an_nxt;
   logic [6:0]          seg_nxt;
   logic                seg_p_nxt;

   assign tick      = (pre_cnt == PRE_LAST);
   assign frame_end = tick && (idx == IDX_LAST);
   assign pwm_on    = (bright == {BRIGHT_W{1'b1}}) || (pwm_cnt < bright);

   // NOTE: state is updated with non-blocking assignments so every flop sees pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pre_cnt <= '0;
         ce1ms   <= 1'b0;
      end else begin
         pre_cnt <= tick ? '0 : pre_cnt + PRE_W'(1);
         ce1ms   <= tick;
      end
   end

   // Explicit wrap keeps a non-power-of-two digit count from reaching an unused index.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx <= '0;
      end else if (tick) begin
         idx <= (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
      end
   end

   // NOTE: staging and shadow are reset so a fresh start never displays stale data.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stg_dat <= '0;
         stg_dp  <= '0;
         shd_dat <= '0;
         shd_dp  <= '0;
         pending <= 1'b0;
      end else begin
         if (frame_end && pending) begin
            shd_dat <= stg_dat;
            shd_dp  <= stg_dp;
         end
         if (load) begin
            stg_dat <= dat;
            stg_dp  <= dp;
         end
         // A load on the boundary edge re-arms pending for the next frame.
         if (load) begin
            pending <= 1'b1;
         end else if (frame_end) begin
            pending <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ms_cnt      <= '0;
         blink_phase <= 1'b0;
      end else if (tick) begin
         if (ms_cnt == BLK_LAST) begin
            ms_cnt      <= '0;
            blink_phase <= ~blink_phase;
         end else begin
            ms_cnt <= ms_cnt + BLK_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pwm_cnt <= '0;
      end else begin
         pwm_cnt <= pwm_cnt + BRIGHT_W'(1);
      end
   end

   // A digit is a leading zero when it and every digit to its left are zero.
   always_comb begin
      logic upper_zero;
      lz_blank   = '0;
      upper_zero = 1'b1;
      for (int i = NDIG - 1; i > 0; i--) begin
         upper_zero  = upper_zero & (shd_dat[4*i +: 4] == 4'h0);
         lz_blank[i] = blank_lz & upper_zero;
      end
   end

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      cur_nib   = 4'h0;
      cur_dp    = 1'b0;
      cur_blink = 1'b0;
      cur_lz    = 1'b0;
      for (int i = 0; i < NDIG; i++) begin
         if (idx == IDX_W'(i)) begin
            cur_nib   = shd_dat[4*i +: 4];
            cur_dp    = shd_dp[i];
            cur_blink = blink_mask[i];
            cur_lz    = lz_blank[i];
         end
      end
   end

   seg_hex7 u_hex7 (
      .nib (cur_nib),
      .seg (hex_seg)
   );

   // A dark slot (PWM off or blinked out) drives segments off as well as the anode.
   always_comb begin
      an_nxt    = '1;
      seg_nxt   = SEG_OFF;
      seg_p_nxt = 1'b1;
      if (pwm_on && !(cur_blink && blink_phase)) begin
         an_nxt    = ~(NDIG'(1) << idx);
         seg_nxt   = cur_lz ? SEG_OFF : hex_seg;
         seg_p_nxt = ~cur_dp;
      end
   end

   // Pins come straight from flops so digit changes cannot glitch.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         AN    <= '1;
         seg   <= SEG_OFF;
         seg_P <= 1'b1;
      end else begin
         AN    <= an_nxt;
         seg   <= seg_nxt;
         seg_P <= seg_p_nxt;
      end
   end

endmodule
